// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: stalls, flushes, pending fetch redirects, fetch timeout.
// Optional perf counters are built when PIPE_CTRL_PERF_CNT_EN is defined; otherwise they read 0.
module pipe_ctrl #(
  parameter int IMEM_TMO = 255,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_use,
  input  logic             id_rs2_use,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_brtaken,
  input  logic [31:0]      ex_target,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  output logic             pcsel,
  output logic [31:0]      pc_tgt,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             fetch_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              WC_W   = $clog2(IMEM_TMO + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(IMEM_TMO);

  typedef enum logic {RUN, PEND} state_t;

  state_t          state_q, state_d;
  logic [31:0]     pend_tgt_q, pend_tgt_d;
  logic [WC_W-1:0] wait_cnt_q;
  logic            fetch_err_q;
  logic            load_use;

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((id_rs1_use && (id_rs1 == ex_rd)) ||
                     (id_rs2_use && (id_rs2 == ex_rd)));

  always_comb begin
    // NOTE: every output is given a default before the priority chain so no path leaves one unassigned (no latches).
    if_en      = 1'b1;
    id_en      = 1'b1;
    ex_en      = 1'b1;
    id_flush   = 1'b0;
    ex_flush   = 1'b0;
    pcsel      = 1'b0;
    pc_tgt     = pend_tgt_q;
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;

    if (dmem_busy) begin
      if_en = 1'b0;
      id_en = 1'b0;
      ex_en = 1'b0;
    end else if (ex_brtaken && imem_ready) begin
      pcsel    = 1'b1;
      pc_tgt   = ex_target;
      id_flush = 1'b1;
      ex_flush = 1'b1;
      state_d  = RUN;
    end else if (ex_brtaken) begin
      // Fetch stage is busy: remember the target and redirect once the outstanding fetch returns.
      if_en      = 1'b0;
      id_flush   = 1'b1;
      ex_flush   = 1'b1;
      pend_tgt_d = ex_target;
      state_d    = PEND;
    end else if (state_q == PEND && imem_ready) begin
      pcsel    = 1'b1;
      pc_tgt   = pend_tgt_q;
      id_flush = 1'b1;
      state_d  = RUN;
    end else if (state_q == PEND) begin
      if_en    = 1'b0;
      id_flush = 1'b1;
    end else if (load_use) begin
      if_en    = 1'b0;
      id_en    = 1'b0;
      ex_flush = 1'b1;
    end else if (!imem_ready) begin
      if_en    = 1'b0;
      id_flush = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pend_tgt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Timeout counter only advances while the fetch is genuinely waiting, not during data stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      if (imem_ready)
        wait_cnt_q <= '0;
      else if (!dmem_busy && wait_cnt_q != WC_MAX)
        wait_cnt_q <= wait_cnt_q + 1'b1;
      if (wait_cnt_q == WC_MAX)
        fetch_err_q <= 1'b1;
    end
  end

  assign fetch_err = fetch_err_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!if_en && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if ((id_flush || ex_flush) && flush_q != '1)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected outputs are queued per step and popped for comparison.
module tb_pipe_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_rs1_use, id_rs2_use, ex_memread, ex_brtaken, imem_ready, dmem_busy;
  logic [31:0]   ex_target;
  logic          pcsel, if_en, id_en, ex_en, id_flush, ex_flush, fetch_err;
  logic [31:0]   pc_tgt;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_ctrl #(.IMEM_TMO(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_brtaken(ex_brtaken), .ex_target(ex_target),
    .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .pcsel(pcsel), .pc_tgt(pc_tgt), .if_en(if_en), .id_en(id_en), .ex_en(ex_en),
    .id_flush(id_flush), .ex_flush(ex_flush), .fetch_err(fetch_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_en, id_en, ex_en, id_flush, ex_flush, pcsel;
    logic [31:0] pc_tgt;
    logic        fetch_err;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] exp_stall = '0;
  logic [CW-1:0] exp_flush = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_use = 1'b0; id_rs2_use = 1'b0;
    ex_rd = 5'd0; ex_memread = 1'b0; ex_brtaken = 1'b0; ex_target = 32'd0;
    imem_ready = 1'b1; dmem_busy = 1'b0;
  endtask

  task automatic expect_out(input logic ie, de, xe, idf, exf, ps, input logic [31:0] tgt,
                            input logic fe);
    exp_t e;
    e.if_en = ie; e.id_en = de; e.ex_en = xe; e.id_flush = idf; e.ex_flush = exf;
    e.pcsel = ps; e.pc_tgt = tgt; e.fetch_err = fe;
    sb.push_back(e);
  endtask

  // Compare current combinational outputs against the oldest queued expectation, then clock once.
  task automatic step(input string tag);
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.scoreboard: observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".if_en"},     32'(if_en),     32'(e.if_en));
      check({tag, ".id_en"},     32'(id_en),     32'(e.id_en));
      check({tag, ".ex_en"},     32'(ex_en),     32'(e.ex_en));
      check({tag, ".id_flush"},  32'(id_flush),  32'(e.id_flush));
      check({tag, ".ex_flush"},  32'(ex_flush),  32'(e.ex_flush));
      check({tag, ".pcsel"},     32'(pcsel),     32'(e.pcsel));
      check({tag, ".pc_tgt"},    pc_tgt,         e.pc_tgt);
      check({tag, ".fetch_err"}, 32'(fetch_err), 32'(e.fetch_err));
      check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
      check({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
`ifdef PIPE_CTRL_PERF_CNT_EN
      if (!e.if_en && exp_stall != '1) exp_stall++;
      if ((e.id_flush || e.ex_flush) && exp_flush != '1) exp_flush++;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_stall = '0;
    exp_flush = '0;
  endtask

  initial begin
    idle();
    do_reset();

    // Reset state
    expect_out(1, 1, 1, 0, 0, 0, 32'h0, 0); step("reset");

    // Load-use hazards
    ex_memread = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_use = 1;
    expect_out(0, 0, 1, 0, 1, 0, 32'h0, 0); step("lu_rs1");
    ex_memread = 0; ex_rd = 5'd7;
    expect_out(1, 1, 1, 0, 0, 0, 32'h0, 0); step("lu_clear");
    idle(); ex_memread = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_use = 1;
    expect_out(1, 1, 1, 0, 0, 0, 32'h0, 0); step("lu_x0");
    idle(); ex_memread = 1; ex_rd = 5'd9; id_rs2 = 5'd9; id_rs2_use = 1;
    expect_out(0, 0, 1, 0, 1, 0, 32'h0, 0); step("lu_rs2");
    id_rs2_use = 0;
    expect_out(1, 1, 1, 0, 0, 0, 32'h0, 0); step("lu_rs2_unused");

    // Branch with fetch ready: immediate redirect
    idle(); ex_brtaken = 1; ex_target = 32'h100;
    expect_out(1, 1, 1, 1, 1, 1, 32'h100, 0); step("br_ready");

    // Branch during a fetch wait: PEND for 3 cycles, then redirect
    idle(); ex_brtaken = 1; ex_target = 32'h200; imem_ready = 0;
    expect_out(0, 1, 1, 1, 1, 0, 32'h0, 0); step("br_wait");
    ex_brtaken = 0; ex_target = 32'h0;
    expect_out(0, 1, 1, 1, 0, 0, 32'h200, 0); step("pend_1");
    expect_out(0, 1, 1, 1, 0, 0, 32'h200, 0); step("pend_2");
    imem_ready = 1;
    expect_out(1, 1, 1, 1, 0, 1, 32'h200, 0); step("pend_ret");
    expect_out(1, 1, 1, 0, 0, 0, 32'h200, 0); step("after_pend");

    // Latest branch in PEND wins
    ex_brtaken = 1; ex_target = 32'h300; imem_ready = 0;
    expect_out(0, 1, 1, 1, 1, 0, 32'h200, 0); step("br2_a");
    ex_target = 32'h340;
    expect_out(0, 1, 1, 1, 1, 0, 32'h300, 0); step("br2_b");
    idle();
    expect_out(1, 1, 1, 1, 0, 1, 32'h340, 0); step("br2_ret");

    // dmem_busy holds a branch; redirect when busy drops
    dmem_busy = 1; ex_brtaken = 1; ex_target = 32'h400;
    expect_out(0, 0, 0, 0, 0, 0, 32'h340, 0); step("busy_br");
    imem_ready = 0;
    expect_out(0, 0, 0, 0, 0, 0, 32'h340, 0); step("busy_noimem");
    dmem_busy = 0; imem_ready = 1;
    expect_out(1, 1, 1, 1, 1, 1, 32'h400, 0); step("busy_drop");

    // Load-use outranks plain fetch wait; fetch wait alone bubbles IF/ID
    idle(); imem_ready = 0;
    expect_out(0, 1, 1, 1, 0, 0, 32'h340, 0); step("imem_wait");
    ex_memread = 1; ex_rd = 5'd3; id_rs1 = 5'd3; id_rs1_use = 1;
    expect_out(0, 0, 1, 0, 1, 0, 32'h340, 0); step("lu_over_wait");
    idle();
    expect_out(1, 1, 1, 0, 0, 0, 32'h340, 0); step("wait_clear");

    // Fetch timeout: 4 waiting cycles, error after the 5th edge, sticky
    imem_ready = 0;
    for (int i = 0; i < TMO; i++) begin
      expect_out(0, 1, 1, 1, 0, 0, 32'h340, 0); step($sformatf("tmo_%0d", i));
    end
    imem_ready = 1;
    expect_out(1, 1, 1, 0, 0, 0, 32'h340, 0); step("tmo_edge5");
    expect_out(1, 1, 1, 0, 0, 0, 32'h340, 1); step("ferr_set");
    expect_out(1, 1, 1, 0, 0, 0, 32'h340, 1); step("ferr_sticky");

    // Reset while PEND discards the redirect
    ex_brtaken = 1; ex_target = 32'h500; imem_ready = 0;
    expect_out(0, 1, 1, 1, 1, 0, 32'h340, 1); step("pre_rst_br");
    do_reset();
    expect_out(1, 1, 1, 0, 0, 0, 32'h0, 0); step("rst_mid_pend");

    // Perf counters: 3 stall cycles then 1 branch
    dmem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      expect_out(0, 0, 0, 0, 0, 0, 32'h0, 0); step($sformatf("perf_stall_%0d", i));
    end
    dmem_busy = 0; ex_brtaken = 1; ex_target = 32'h600;
    expect_out(1, 1, 1, 1, 1, 1, 32'h600, 0); step("perf_br");
    idle();
    expect_out(1, 1, 1, 0, 0, 0, 32'h0, 0); step("perf_read");
`ifdef PIPE_CTRL_PERF_CNT_EN
    check("perf_stall_total", 32'(stall_cnt), 32'd3);
    check("perf_flush_total", 32'(flush_cnt), 32'd1);
`else
    check("perf_stall_tied", 32'(stall_cnt), 32'd0);
    check("perf_flush_tied", 32'(flush_cnt), 32'd0);
`endif

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
